// File: rtl/line_xfer_engine.sv
// Cache-line transfer sequencer: moves one line between cache and memory as
// WORDS_PER_LINE handshaked single-word beats (refill is critical-word-first).
module line_xfer_engine #(
    parameter int AWIDTH         = 9,
    parameter int DWIDTH         = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int TIMEOUT        = 15
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [AWIDTH-1:0]                 req_addr,
    output logic [$clog2(WORDS_PER_LINE)-1:0] wb_idx,
    input  logic [DWIDTH-1:0]                 wb_data,
    output logic                              fill_valid,
    output logic [DWIDTH-1:0]                 fill_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_idx,
    output logic                              done,
    output logic                              err,
    output logic                              mem_rd,
    output logic                              mem_wr,
    output logic [AWIDTH-1:0]                 mem_addr,
    output logic [DWIDTH-1:0]                 mem_wdata,
    input  logic [DWIDTH-1:0]                 mem_rdata,
    input  logic                              mem_ready
);

    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int LW = AWIDTH - OW;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   line_q, line_d;
    logic            write_q, write_d;
    logic [OW-1:0]   start_q, start_d;
    logic [OW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   wait_q, wait_d;
    logic            err_q, err_d;
    logic            fill_valid_q, fill_valid_d;
    logic [DWIDTH-1:0] fill_data_q, fill_data_d;
    logic [OW-1:0]   fill_idx_q, fill_idx_d;

    logic [OW-1:0]   offset;
    logic            beat_done;
    logic            last_beat;
    logic            timed_out;

    // Offset wraps within the line for free because it is only OW bits wide.
    assign offset    = start_q + cnt_q;
    assign beat_done = (state_q == S_XFER) && mem_ready;
    assign last_beat = beat_done && (cnt_q == '1);
    assign timed_out = TO_EN && (state_q == S_XFER) && !mem_ready && (wait_q == TO_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_XFER;
            S_XFER:  if (last_beat || timed_out) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_XFER: begin
                mem_rd = !write_q;
                mem_wr = write_q;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    assign mem_addr   = {line_q, offset};
    assign wb_idx     = offset;
    assign mem_wdata  = ((state_q == S_XFER) && write_q) ? wb_data : '0;
    assign fill_valid = fill_valid_q;
    assign fill_data  = fill_data_q;
    assign fill_idx   = fill_idx_q;

    always_comb begin
        line_d       = line_q;
        write_d      = write_q;
        start_d      = start_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        err_d        = err_q;
        fill_valid_d = 1'b0;
        fill_data_d  = fill_data_q;
        fill_idx_d   = fill_idx_q;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                wait_d = '0;
                err_d  = 1'b0;
                if (req_valid) begin
                    line_d  = req_addr[AWIDTH-1:OW];
                    write_d = req_write;
                    start_d = req_write ? '0 : req_addr[OW-1:0];
                end
            end
            S_XFER: begin
                err_d = timed_out;
                if (mem_ready) begin
                    cnt_d  = cnt_q + 1'b1;
                    wait_d = '0;
                end else if (TO_EN) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Refill words are registered so the cache sees a clean one-cycle strobe.
        if (beat_done && !write_q) begin
            fill_valid_d = 1'b1;
            fill_data_d  = mem_rdata;
            fill_idx_d   = offset;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            line_q       <= '0;
            write_q      <= 1'b0;
            start_q      <= '0;
            cnt_q        <= '0;
            wait_q       <= '0;
            err_q        <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_data_q  <= '0;
            fill_idx_q   <= '0;
        end else begin
            line_q       <= line_d;
            write_q      <= write_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            err_q        <= err_d;
            fill_valid_q <= fill_valid_d;
            fill_data_q  <= fill_data_d;
            fill_idx_q   <= fill_idx_d;
        end
    end

endmodule

// File: tb/tb_line_xfer_engine.sv
// Scoreboard bench for line_xfer_engine: a 4-word instance with TIMEOUT=8 and
// an 8-word, 32-bit instance, driven with hand-written address vectors.
module tb_line_xfer_engine;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // DUT0: W=4, DWIDTH=8, TIMEOUT=8
    logic       rst0, rv0, rw0, rr0, fv0, dn0, er0, mrd0, mwr0, mrdy0;
    logic [8:0] ra0, ma0;
    logic [1:0] wbi0, fi0;
    logic [7:0] wbd0, fd0, mwd0, mrdata0;

    // DUT1: W=8, DWIDTH=32
    logic        rst1, rv1, rw1, rr1, fv1, dn1, er1, mrd1, mwr1, mrdy1;
    logic [8:0]  ra1, ma1;
    logic [2:0]  wbi1, fi1;
    logic [31:0] wbd1, fd1, mwd1, mrdata1;

    line_xfer_engine #(.AWIDTH(9), .DWIDTH(8), .WORDS_PER_LINE(4), .TIMEOUT(8)) dut0 (
        .clock(clock), .reset(rst0), .req_valid(rv0), .req_ready(rr0), .req_write(rw0),
        .req_addr(ra0), .wb_idx(wbi0), .wb_data(wbd0), .fill_valid(fv0), .fill_data(fd0),
        .fill_idx(fi0), .done(dn0), .err(er0), .mem_rd(mrd0), .mem_wr(mwr0),
        .mem_addr(ma0), .mem_wdata(mwd0), .mem_rdata(mrdata0), .mem_ready(mrdy0)
    );

    line_xfer_engine #(.AWIDTH(9), .DWIDTH(32), .WORDS_PER_LINE(8), .TIMEOUT(15)) dut1 (
        .clock(clock), .reset(rst1), .req_valid(rv1), .req_ready(rr1), .req_write(rw1),
        .req_addr(ra1), .wb_idx(wbi1), .wb_data(wbd1), .fill_valid(fv1), .fill_data(fd1),
        .fill_idx(fi1), .done(dn1), .err(er1), .mem_rd(mrd1), .mem_wr(mwr1),
        .mem_addr(ma1), .mem_wdata(mwd1), .mem_rdata(mrdata1), .mem_ready(mrdy1)
    );

    // Memory/cache models. mode 0: always ready; 1: two wait cycles per beat; 2: never ready.
    int mode = 0;
    int wcnt = 0;
    logic [7:0] cache0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    assign mrdy0   = (mode == 0) || (mode == 1 && wcnt == 2);
    assign mrdata0 = ma0[7:0] ^ 8'h5A;
    assign wbd0    = cache0[wbi0];
    assign mrdy1   = 1'b1;
    assign mrdata1 = {ma1[7:0], ~ma1[7:0], 7'h0, ma1};
    assign wbd1    = 32'hC0DE_0000 | {29'h0, wbi1};

    always @(posedge clock) begin
        if (mrd0 || mwr0) wcnt <= mrdy0 ? 0 : wcnt + 1;
        else              wcnt <= 0;
    end

    function automatic logic [31:0] exp_rdata(input int d, input logic [8:0] a);
        return (d == 0) ? {24'h0, a[7:0] ^ 8'h5A} : {a[7:0], ~a[7:0], 7'h0, a};
    endfunction

    function automatic logic [31:0] exp_wdata(input int d, input logic [2:0] idx);
        return (d == 0) ? {24'h0, cache0[idx[1:0]]} : (32'hC0DE_0000 | {29'h0, idx});
    endfunction

    typedef struct { int d; int cyc; logic [8:0] addr; logic wr; logic [31:0] wdata; } strobe_t;
    typedef struct { int d; int cyc; logic [2:0] idx; logic [31:0] data; } fill_t;
    typedef struct { int d; int cyc; logic err; } done_t;

    strobe_t sq[$];
    fill_t   fq[$];
    done_t   dq[$];

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] vec_addr [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic rd, input logic wr, input logic [8:0] addr,
                       input logic [31:0] wdata, input logic fv, input logic [2:0] fidx,
                       input logic [31:0] fdata, input logic dn, input logic er);
        strobe_t s;
        fill_t   f;
        done_t   e;
        if (rd && wr) check($sformatf("d%0d rd/wr together", d), 1, 0);
        if (rd || wr) begin
            if (sq.size() == 0 || sq[0].d != d) begin
                check($sformatf("d%0d unexpected strobe", d), 1, 0);
            end else begin
                s = sq.pop_front();
                check($sformatf("d%0d strobe cycle", d), cyc, s.cyc);
                check($sformatf("d%0d mem_addr", d), addr, s.addr);
                check($sformatf("d%0d mem_wr", d), wr, s.wr);
                check($sformatf("d%0d mem_wdata", d), wdata, s.wdata);
            end
        end
        if (fv) begin
            if (fq.size() == 0 || fq[0].d != d) begin
                check($sformatf("d%0d unexpected fill_valid", d), 1, 0);
            end else begin
                f = fq.pop_front();
                check($sformatf("d%0d fill cycle", d), cyc, f.cyc);
                check($sformatf("d%0d fill_idx", d), fidx, f.idx);
                check($sformatf("d%0d fill_data", d), fdata, f.data);
            end
        end
        if (dn) begin
            if (dq.size() == 0 || dq[0].d != d) begin
                check($sformatf("d%0d unexpected done", d), 1, 0);
            end else begin
                e = dq.pop_front();
                check($sformatf("d%0d done cycle", d), cyc, e.cyc);
                check($sformatf("d%0d err", d), er, e.err);
            end
        end
        if (er && !dn) check($sformatf("d%0d err without done", d), 1, 0);
    endtask

    always @(negedge clock) begin
        if (cyc > 2) begin
            mon(0, mrd0, mwr0, ma0, {24'h0, mwd0}, fv0, {1'b0, fi0}, {24'h0, fd0}, dn0, er0);
            mon(1, mrd1, mwr1, ma1, mwd1, fv1, fi1, fd1, dn1, er1);
        end
    end

    // Returns t0 = cycle in which the request handshake happens.
    task automatic do_req(input int d, input logic wr, input logic [8:0] addr,
                          input bit keep, output int t0);
        bit got = 1'b0;
        if (d == 0) begin rv0 = 1'b1; rw0 = wr; ra0 = addr; end
        else        begin rv1 = 1'b1; rw1 = wr; ra1 = addr; end
        t0 = cyc;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if ((d == 0) ? rr0 : rr1) begin
                got = 1'b1;
                t0  = cyc;
            end
        end
        check($sformatf("d%0d request accepted", d), got, 1);
        @(posedge clock);
        #1;
        if (!keep) begin rv0 = 1'b0; rv1 = 1'b0; end
    endtask

    // span = cycles each beat's strobe is held (1 = no wait states).
    task automatic push_vec(input int d, input int t0, input logic wr, input int span, input int n);
        logic [8:0] a;
        logic [2:0] idx;
        for (int i = 0; i < n; i++) begin
            a   = vec_addr[i];
            idx = (d == 0) ? {1'b0, a[1:0]} : a[2:0];
            for (int k = 0; k < span; k++)
                sq.push_back(strobe_t'{d, t0 + 1 + span * i + k, a, wr, wr ? exp_wdata(d, idx) : 32'h0});
            if (!wr) fq.push_back(fill_t'{d, t0 + span * (i + 1) + 1, idx, exp_rdata(d, a)});
        end
        dq.push_back(done_t'{d, t0 + span * n + 1, 1'b0});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && (sq.size() + fq.size() + dq.size()) != 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        check(name, sq.size() + fq.size() + dq.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, ta, tb;
        rst0 = 1'b1; rst1 = 1'b1;
        rv0 = 1'b0; rw0 = 1'b0; ra0 = '0;
        rv1 = 1'b0; rw1 = 1'b0; ra1 = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset req_ready",  rr0, 1);
        check("reset mem_rd",     mrd0, 0);
        check("reset mem_wr",     mwr0, 0);
        check("reset fill_valid", fv0, 0);
        check("reset done",       dn0, 0);
        check("reset err",        er0, 0);
        check("reset mem_addr",   ma0, 0);
        check("reset fill_idx",   fi0, 0);
        check("reset d1 req_ready", rr1, 1);
        @(posedge clock);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Refill, critical word 2: 0A6,0A7,0A4,0A5
        vec_addr = '{9'h0A6, 9'h0A7, 9'h0A4, 9'h0A5, 9'h0, 9'h0, 9'h0, 9'h0};
        do_req(0, 1'b0, 9'h0A6, 1'b0, t0);
        push_vec(0, t0, 1'b0, 1, 4);
        drain("refill 0A6 drained");

        // Writeback always starts at offset 0
        vec_addr = '{9'h130, 9'h131, 9'h132, 9'h133, 9'h0, 9'h0, 9'h0, 9'h0};
        do_req(0, 1'b1, 9'h133, 1'b0, t0);
        push_vec(0, t0, 1'b1, 1, 4);
        drain("writeback 133 drained");

        // Two wait cycles before every beat: done at cycle 13
        mode = 1;
        vec_addr = '{9'h1F5, 9'h1F6, 9'h1F7, 9'h1F4, 9'h0, 9'h0, 9'h0, 9'h0};
        do_req(0, 1'b0, 9'h1F5, 1'b0, t0);
        push_vec(0, t0, 1'b0, 3, 4);
        drain("wait-state refill drained");
        mode = 0;

        // Timeout: strobe cycles 1-8, done+err at 9, ready again at 10
        mode = 2;
        do_req(0, 1'b0, 9'h0F1, 1'b0, t0);
        for (int k = 1; k <= 8; k++) sq.push_back(strobe_t'{0, t0 + k, 9'h0F1, 1'b0, 32'h0});
        dq.push_back(done_t'{0, t0 + 9, 1'b1});
        repeat (9) @(negedge clock);
        check("req_ready in DONE after timeout", rr0, 0);
        @(negedge clock);
        check("req_ready after timeout", rr0, 1);
        mode = 0;
        drain("timeout drained");

        // Reset during the third beat: no further fill/done
        do_req(0, 1'b0, 9'h052, 1'b0, t0);
        sq.push_back(strobe_t'{0, t0 + 1, 9'h052, 1'b0, 32'h0});
        sq.push_back(strobe_t'{0, t0 + 2, 9'h053, 1'b0, 32'h0});
        sq.push_back(strobe_t'{0, t0 + 3, 9'h050, 1'b0, 32'h0});
        fq.push_back(fill_t'{0, t0 + 2, 3'd2, exp_rdata(0, 9'h052)});
        fq.push_back(fill_t'{0, t0 + 3, 3'd3, exp_rdata(0, 9'h053)});
        repeat (2) @(posedge clock);
        #1 rst0 = 1'b1;
        @(posedge clock);
        #1 rst0 = 1'b0;
        @(negedge clock);
        check("after reset mem_rd",     mrd0, 0);
        check("after reset req_ready",  rr0, 1);
        check("after reset fill_valid", fv0, 0);
        check("after reset mem_addr",   ma0, 0);
        repeat (5) @(negedge clock);
        drain("reset abort drained");

        // Held req_valid: second request accepted at cycle W+2
        vec_addr = '{9'h0A9, 9'h0AA, 9'h0AB, 9'h0A8, 9'h0, 9'h0, 9'h0, 9'h0};
        do_req(0, 1'b0, 9'h0A9, 1'b1, ta);
        push_vec(0, ta, 1'b0, 1, 4);
        vec_addr = '{9'h02C, 9'h02D, 9'h02E, 9'h02F, 9'h0, 9'h0, 9'h0, 9'h0};
        do_req(0, 1'b1, 9'h02E, 1'b0, tb);
        push_vec(0, tb, 1'b1, 1, 4);
        check("back-to-back accept spacing", tb - ta, 6);
        drain("back-to-back drained");

        // 8-word line, 32-bit data, wraps 07F -> 078
        vec_addr = '{9'h07D, 9'h07E, 9'h07F, 9'h078, 9'h079, 9'h07A, 9'h07B, 9'h07C};
        do_req(1, 1'b0, 9'h07D, 1'b0, t0);
        push_vec(1, t0, 1'b0, 1, 8);
        drain("8-word refill drained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
